time_entry_buffer: RTL and testbench

TIME_ENTRY_BUFFER -- requirements
Module: time_entry_buffer

---
 rtl/time_entry_buffer.sv | 168 ++++++++++++++++
 tb/tb_time_entry_buffer.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/time_entry_buffer.sv
// MM:SS keypad entry buffer: debounces BCD digits, shifts them in from the right and commits on start_key.
// Optional macro SECONDS_CLAMP_EN clamps a seconds-tens digit of 6..9 to 59 at commit.
module time_entry_buffer #(
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] D,
  input  logic       valid,
  input  logic       clear_key,
  input  logic       start_key,
  output logic [3:0] min_tens,
  output logic [3:0] min_ones,
  output logic [3:0] sec_tens,
  output logic [3:0] sec_ones,
  output logic [2:0] digit_count,
  output logic       load,
  output logic       locked,
  output logic [1:0] dbg_state
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ENTRY  = 2'd1,
    S_FULL   = 2'd2,
    S_LOCKED = 2'd3
  } state_t;

  localparam logic [3:0] DEB = DEBOUNCE_CYCLES[3:0];

  state_t     r_state;
  state_t     w_state_next;

  logic [3:0] r_prev_d;
  logic       r_prev_valid;
  logic [3:0] r_cnt;
  logic       r_armed;
  logic       r_start_prev;

  logic [3:0] r_min_tens;
  logic [3:0] r_min_ones;
  logic [3:0] r_sec_tens;
  logic [3:0] r_sec_ones;
  logic [2:0] r_count;
  logic       r_load;

  logic [3:0] w_run;
  logic       w_fire;
  logic       w_digit_ok;
  logic       w_start_rise;
  logic       w_commit;
  logic       w_accept;

  // w_run is the length of the current steady press including this cycle.
  always_comb begin
    w_run = 4'd0;
    if (valid) begin
      if (r_prev_valid && (D == r_prev_d)) begin
        w_run = (r_cnt == 4'hF) ? r_cnt : (r_cnt + 4'd1);
      end else begin
        w_run = 4'd1;
      end
    end
  end

  always_comb begin
    w_fire       = r_armed && valid && (w_run == DEB);
    w_digit_ok   = (D <= 4'd9);
    w_start_rise = start_key && !r_start_prev;
    w_commit     = w_start_rise && !clear_key &&
                   ((r_state == S_ENTRY) || (r_state == S_FULL));
    // Clear and commit both win over a digit finishing its debounce this cycle.
    w_accept     = w_fire && w_digit_ok && !clear_key && !w_commit &&
                   ((r_state == S_IDLE) || (r_state == S_ENTRY));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    if (clear_key) begin
      w_state_next = S_IDLE;
    end else if (w_commit) begin
      w_state_next = S_LOCKED;
    end else if (w_accept) begin
      case (r_state)
        S_IDLE:  w_state_next = S_ENTRY;
        S_ENTRY: w_state_next = (r_count == 3'd3) ? S_FULL : S_ENTRY;
        default: w_state_next = r_state;
      endcase
    end
  end

  always_comb begin
    locked    = (r_state == S_LOCKED);
    dbg_state = r_state;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_prev_d     <= 4'd0;
      r_prev_valid <= 1'b0;
      r_cnt        <= 4'd0;
      r_armed      <= 1'b1;
      r_start_prev <= 1'b0;
    end else begin
      r_prev_d     <= D;
      r_prev_valid <= valid;
      r_cnt        <= w_run;
      r_start_prev <= start_key;
      // A fired press stays consumed until the key is released.
      if (!valid) begin
        r_armed <= 1'b1;
      end else if (w_fire) begin
        r_armed <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_min_tens <= 4'd0;
      r_min_ones <= 4'd0;
      r_sec_tens <= 4'd0;
      r_sec_ones <= 4'd0;
      r_count    <= 3'd0;
      r_load     <= 1'b0;
    end else begin
      r_load <= w_commit;
      if (clear_key) begin
        r_min_tens <= 4'd0;
        r_min_ones <= 4'd0;
        r_sec_tens <= 4'd0;
        r_sec_ones <= 4'd0;
        r_count    <= 3'd0;
      end else if (w_commit) begin
`ifdef SECONDS_CLAMP_EN
        if (r_sec_tens >= 4'd6) begin
          r_sec_tens <= 4'd5;
          r_sec_ones <= 4'd9;
        end
`else
        r_sec_tens <= r_sec_tens;
`endif
      end else if (w_accept) begin
        r_min_tens <= r_min_ones;
        r_min_ones <= r_sec_tens;
        r_sec_tens <= r_sec_ones;
        r_sec_ones <= D;
        r_count    <= r_count + 3'd1;
      end
    end
  end

  assign min_tens    = r_min_tens;
  assign min_ones    = r_min_ones;
  assign sec_tens    = r_sec_tens;
  assign sec_ones    = r_sec_ones;
  assign digit_count = r_count;
  assign load        = r_load;

endmodule

// File: tb/tb_time_entry_buffer.sv
// Bench for time_entry_buffer: directed scenarios plus randomized presses against a press-level model.
module tb_time_entry_buffer;

  localparam int DEB = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] D;
  logic       valid, clear_key, start_key;
  logic [3:0] min_tens, min_ones, sec_tens, sec_ones;
  logic [2:0] digit_count;
  logic       load, locked;
  logic [1:0] dbg_state;

  int n_checks = 0;
  int n_pass   = 0;
  int load_seen = 0;
  int exp_loads = 0;

  // Model: displayed digits left to right, accepted-digit count, lock flag.
  logic [3:0] m_disp[4];
  int         m_count;
  bit         m_locked;

  time_entry_buffer #(.DEBOUNCE_CYCLES(DEB)) dut (
    .clk(clk), .rst(rst), .D(D), .valid(valid), .clear_key(clear_key),
    .start_key(start_key), .min_tens(min_tens), .min_ones(min_ones),
    .sec_tens(sec_tens), .sec_ones(sec_ones), .digit_count(digit_count),
    .load(load), .locked(locked), .dbg_state(dbg_state)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    #1;
    if (load === 1'b1) load_seen++;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: run did not finish, got=timeout expected=finish");
    $fatal(1);
  end

  function automatic logic [15:0] got_disp();
    return {min_tens, min_ones, sec_tens, sec_ones};
  endfunction

  function automatic logic [15:0] exp_disp();
    return {m_disp[0], m_disp[1], m_disp[2], m_disp[3]};
  endfunction

  function automatic void m_reset();
    for (int i = 0; i < 4; i++) m_disp[i] = 4'd0;
    m_count  = 0;
    m_locked = 0;
  endfunction

  function automatic void m_press(input logic [3:0] d, input int hold);
    if (hold >= DEB && d <= 4'd9 && !m_locked && m_count < 4) begin
      for (int i = 0; i < 3; i++) m_disp[i] = m_disp[i+1];
      m_disp[3] = d;
      m_count++;
    end
  endfunction

  function automatic void m_start();
    if (!m_locked && m_count > 0) begin
      m_locked = 1;
      exp_loads++;
`ifdef SECONDS_CLAMP_EN
      if (m_disp[2] >= 4'd6) begin
        m_disp[2] = 4'd5;
        m_disp[3] = 4'd9;
      end
`endif
    end
  endfunction

  // All drivers start and end just after a falling edge.
  task automatic drive_press(input logic [3:0] d, input int hold, input int gap);
    D = d;
    valid = 1'b1;
    repeat (hold) @(negedge clk);
    valid = 1'b0;
    repeat (gap) @(negedge clk);
    m_press(d, hold);
  endtask

  task automatic drive_start(input int len);
    start_key = 1'b1;
    repeat (len) @(negedge clk);
    start_key = 1'b0;
    @(negedge clk);
    m_start();
  endtask

  task automatic drive_clear();
    clear_key = 1'b1;
    @(negedge clk);
    clear_key = 1'b0;
    @(negedge clk);
    m_reset();
  endtask

  task automatic test_reset();
    rst = 1'b1; D = 4'd0; valid = 1'b0; clear_key = 1'b0; start_key = 1'b0;
    m_reset();
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    n_checks++; if (got_disp() !== 16'h0000) $display("FAIL reset_digits got=%h expected=0000", got_disp()); else n_pass++;
    n_checks++; if (digit_count !== 3'd0) $display("FAIL reset_count got=%0d expected=0", digit_count); else n_pass++;
    n_checks++; if (locked !== 1'b0 || load !== 1'b0) $display("FAIL reset_flags got=locked%b/load%b expected=0/0", locked, load); else n_pass++;
  endtask

  task automatic test_single_hold();
    D = 4'd7;
    valid = 1'b1;
    repeat (DEB - 1) @(negedge clk);
    n_checks++; if (digit_count !== 3'd0) $display("FAIL hold_early got=%0d expected=0", digit_count); else n_pass++;
    @(negedge clk);
    m_press(4'd7, DEB);
    n_checks++; if (got_disp() !== exp_disp() || digit_count !== 3'd1) $display("FAIL hold_accept got=%h/%0d expected=%h/1", got_disp(), digit_count, exp_disp()); else n_pass++;
    repeat (20) @(negedge clk);
    n_checks++; if (got_disp() !== exp_disp() || digit_count !== 3'd1) $display("FAIL hold_long got=%h/%0d expected=%h/1", got_disp(), digit_count, exp_disp()); else n_pass++;
    valid = 1'b0;
    @(negedge clk);
    drive_clear();
    n_checks++; if (got_disp() !== 16'h0000 || digit_count !== 3'd0) $display("FAIL clear got=%h/%0d expected=0000/0", got_disp(), digit_count); else n_pass++;
  endtask

  task automatic test_fill();
    logic [3:0] seq[5];
    seq = '{4'd1, 4'd2, 4'd3, 4'd0, 4'd8};
    for (int i = 0; i < 5; i++) drive_press(seq[i], DEB + i % 2, 2);
    n_checks++; if (got_disp() !== 16'h1230) $display("FAIL fill_digits got=%h expected=1230", got_disp()); else n_pass++;
    n_checks++; if (digit_count !== 3'd4 || dbg_state !== 2'd2) $display("FAIL fill_count got=%0d/st%0d expected=4/st2", digit_count, dbg_state); else n_pass++;
    drive_clear();
  endtask

  task automatic test_reject();
    drive_press(4'd5, 2, 1);
    drive_press(4'd12, DEB, 1);
    drive_press(4'd15, DEB + 6, 1);
    n_checks++; if (digit_count !== 3'd0 || got_disp() !== 16'h0000) $display("FAIL reject got=%h/%0d expected=0000/0", got_disp(), digit_count); else n_pass++;
  endtask

  task automatic test_commit();
    drive_press(4'd9, DEB, 1);
    drive_press(4'd9, DEB, 1);
    drive_start(3);
    n_checks++; if (load_seen !== exp_loads) $display("FAIL commit_load got=%0d expected=%0d", load_seen, exp_loads); else n_pass++;
    n_checks++; if (locked !== 1'b1 || dbg_state !== 2'd3) $display("FAIL commit_locked got=%b/st%0d expected=1/st3", locked, dbg_state); else n_pass++;
`ifdef SECONDS_CLAMP_EN
    n_checks++; if (got_disp() !== 16'h0059) $display("FAIL commit_digits got=%h expected=0059", got_disp()); else n_pass++;
`else
    n_checks++; if (got_disp() !== 16'h0099) $display("FAIL commit_digits got=%h expected=0099", got_disp()); else n_pass++;
`endif
    drive_press(4'd4, DEB + 2, 1);
    drive_start(2);
    n_checks++; if (got_disp() !== exp_disp() || load_seen !== exp_loads) $display("FAIL locked_hold got=%h/%0d expected=%h/%0d", got_disp(), load_seen, exp_disp(), exp_loads); else n_pass++;
  endtask

  task automatic test_priority();
    // Locked: clear, start rise and a finishing digit in one cycle.
    D = 4'd3;
    valid = 1'b1;
    repeat (DEB - 1) @(negedge clk);
    clear_key = 1'b1; start_key = 1'b1;
    @(negedge clk);
    clear_key = 1'b0; start_key = 1'b0; valid = 1'b0;
    @(negedge clk);
    m_reset();
    n_checks++; if (got_disp() !== 16'h0000 || digit_count !== 3'd0 || locked !== 1'b0) $display("FAIL clr_locked got=%h/%0d/%b expected=0000/0/0", got_disp(), digit_count, locked); else n_pass++;
    n_checks++; if (load_seen !== exp_loads) $display("FAIL clr_noload got=%0d expected=%0d", load_seen, exp_loads); else n_pass++;
    // Entry: clear against start.
    drive_press(4'd2, DEB, 1);
    clear_key = 1'b1; start_key = 1'b1;
    @(negedge clk);
    clear_key = 1'b0; start_key = 1'b0;
    @(negedge clk);
    m_reset();
    n_checks++; if (locked !== 1'b0 || digit_count !== 3'd0 || load_seen !== exp_loads) $display("FAIL clr_vs_start got=%b/%0d/%0d expected=0/0/%0d", locked, digit_count, load_seen, exp_loads); else n_pass++;
    // Entry: start against a finishing digit, which is dropped.
    drive_press(4'd1, DEB, 1);
    D = 4'd6;
    valid = 1'b1;
    repeat (DEB - 1) @(negedge clk);
    start_key = 1'b1;
    @(negedge clk);
    start_key = 1'b0; valid = 1'b0;
    @(negedge clk);
    m_start();
    n_checks++; if (got_disp() !== exp_disp() || locked !== 1'b1 || load_seen !== exp_loads) $display("FAIL start_vs_digit got=%h/%b/%0d expected=%h/1/%0d", got_disp(), locked, load_seen, exp_disp(), exp_loads); else n_pass++;
    drive_clear();
  endtask

  task automatic test_async_reset();
    drive_press(4'd5, DEB, 1);
    D = 4'd8;
    valid = 1'b1;
    repeat (2) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    n_checks++; if (got_disp() !== 16'h0000 || digit_count !== 3'd0) $display("FAIL arst_debounce got=%h/%0d expected=0000/0", got_disp(), digit_count); else n_pass++;
    @(negedge clk);
    rst = 1'b0;
    m_reset();
    repeat (DEB - 1) @(negedge clk);
    n_checks++; if (digit_count !== 3'd0) $display("FAIL arst_recount got=%0d expected=0", digit_count); else n_pass++;
    @(negedge clk);
    m_press(4'd8, DEB);
    n_checks++; if (got_disp() !== exp_disp() || digit_count !== 3'd1) $display("FAIL arst_accept got=%h/%0d expected=%h/1", got_disp(), digit_count, exp_disp()); else n_pass++;
    valid = 1'b0;
    @(negedge clk);
    drive_start(1);
    #2 rst = 1'b1;
    #1;
    n_checks++; if (locked !== 1'b0 || got_disp() !== 16'h0000 || load !== 1'b0) $display("FAIL arst_locked got=%b/%h/%b expected=0/0000/0", locked, got_disp(), load); else n_pass++;
    @(negedge clk);
    rst = 1'b0;
    m_reset();
    @(negedge clk);
  endtask

  task automatic test_random();
    int r;
    for (int i = 0; i < 80; i++) begin
      r = $urandom_range(0, 9);
      if (r < 7) begin
        drive_press(4'($urandom_range(0, 11)), $urandom_range(1, DEB + 3), $urandom_range(1, 3));
      end else if (r < 9) begin
        drive_start($urandom_range(1, 3));
      end else begin
        drive_clear();
      end
      n_checks++; if (got_disp() !== exp_disp() || digit_count !== 3'(m_count)) $display("FAIL rand_digits step=%0d got=%h/%0d expected=%h/%0d", i, got_disp(), digit_count, exp_disp(), m_count); else n_pass++;
      n_checks++; if (locked !== m_locked || load_seen !== exp_loads) $display("FAIL rand_flags step=%0d got=%b/%0d expected=%b/%0d", i, locked, load_seen, m_locked, exp_loads); else n_pass++;
    end
  endtask

  initial begin
    test_reset();
    test_single_hold();
    test_fill();
    test_reject();
    test_commit();
    test_priority();
    test_async_reset();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
